// File: rtl/iram_frame_reader.sv
// iram_frame_reader: reads the 8x8 frame back out of IRAM after the LCD
// controller finishes, streams raster-ordered pixels with x/y/last over
// valid/ready, and keeps a 16-bit running checksum of accepted pixels.
module iram_frame_reader #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          IRAM_ceb,
  output logic          IRAM_web,
  output logic [AW-1:0] IRAM_A,
  input  logic [DW-1:0] IRAM_Q,
  output logic          px_valid,
  input  logic          px_ready,
  output logic [DW-1:0] px_data,
  output logic [2:0]    px_x,
  output logic [2:0]    px_y,
  output logic          px_last,
  output logic [15:0]   checksum,
  output logic          busy,
  output logic          done
);

  localparam int unsigned XW = 3;
  localparam int unsigned CW = 16;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   checksum_q, checksum_d;
  logic            busy_q, done_q;

  // Read issued last cycle: its data is on IRAM_Q this cycle.
  logic            pend_q;
  logic [AW-1:0]   pend_idx_q;

  // 2-entry pixel buffer
  logic [DW-1:0]   data_q [2];
  logic [AW-1:0]   idx_q  [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      cnt_q;

  logic            issue_c;
  logic            clr_c;
  logic            pop_c;
  logic [2:0]      level_c;
  logic [AW-1:0]   head_idx_c;

  assign px_valid   = (cnt_q != 2'd0);
  assign pop_c      = px_valid & px_ready;
  assign head_idx_c = idx_q[rd_ptr_q];
  // Entries that will occupy the buffer once the pending read lands and
  // this cycle's pop retires; a new read is allowed only if it still fits.
  assign level_c    = 3'(cnt_q) + 3'(pend_q) - 3'(pop_c);

  // Next-state, read issue and checksum update
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issue_c    = 1'b0;
    clr_c      = 1'b0;
    checksum_d = checksum_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          addr_d  = '0;
          clr_c   = 1'b1;
        end
      end
      S_READ: begin
        if (level_c < 3'd2) begin
          issue_c = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      S_DRAIN: begin
        // Leave once nothing is in flight and the last entry is being taken.
        if (!pend_q && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop_c))) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (clr_c) begin
      checksum_d = '0;
    end else if (pop_c) begin
      checksum_d = checksum_q + CW'(px_data);
    end
  end

  // FSM, address pointer, checksum and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      checksum_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      checksum_q <= checksum_d;
      busy_q     <= (state_d == S_READ) || (state_d == S_DRAIN);
      done_q     <= (state_d == S_FIN);
      pend_q     <= issue_c;
      if (issue_c) begin
        pend_idx_q <= addr_q;
      end
    end
  end

  // Pixel buffer: push IRAM data with its index, pop on accepted beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        idx_q[i]  <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (pend_q) begin
        data_q[wr_ptr_q] <= IRAM_Q;
        idx_q[wr_ptr_q]  <= pend_idx_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + 2'(pend_q) - 2'(pop_c);
    end
  end

  // Read issue is decided in the cycle it happens so a held-high ready
  // sustains one pixel per cycle with only two buffer entries.
  assign IRAM_ceb = issue_c;
  assign IRAM_web = 1'b1;
  assign IRAM_A   = addr_q;

  assign px_data  = data_q[rd_ptr_q];
  assign px_x     = head_idx_c[XW-1:0];
  assign px_y     = head_idx_c[2*XW-1:XW];
  assign px_last  = px_valid && (head_idx_c == LAST_ADDR);
  assign checksum = checksum_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_iram_frame_reader.sv
// Directed bench for iram_frame_reader with a synchronous IRAM model.
module tb_iram_frame_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        IRAM_ceb;
  logic        IRAM_web;
  logic [5:0]  IRAM_A;
  logic [7:0]  IRAM_Q;
  logic        px_valid;
  logic        px_ready;
  logic [7:0]  px_data;
  logic [2:0]  px_x;
  logic [2:0]  px_y;
  logic        px_last;
  logic [15:0] checksum;
  logic        busy;
  logic        done;

  logic [7:0]  mem [64];

  int checks = 0;
  int passes = 0;

  int cyc = 0;
  int iss = 0;
  int acc = 0;
  int max_out = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int web_bad = 0;
  int q_data[$];
  int q_x[$];
  int q_y[$];
  int q_last[$];
  int q_cyc[$];

  iram_frame_reader #(.DW(8), .AW(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .IRAM_ceb (IRAM_ceb),
    .IRAM_web (IRAM_web),
    .IRAM_A   (IRAM_A),
    .IRAM_Q   (IRAM_Q),
    .px_valid (px_valid),
    .px_ready (px_ready),
    .px_data  (px_data),
    .px_x     (px_x),
    .px_y     (px_y),
    .px_last  (px_last),
    .checksum (checksum),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read IRAM
  always @(posedge clk) begin
    if (IRAM_ceb) IRAM_Q <= mem[IRAM_A];
  end

  // Edge counter: during cycle n (ending at edge n) cyc holds n-1.
  always @(posedge clk) cyc = cyc + 1;

  // Mid-cycle monitor: records beats, done pulses and reads outstanding.
  always @(negedge clk) begin
    if (rst_n) begin
      if (IRAM_ceb) iss = iss + 1;
      if (px_valid && px_ready) begin
        acc = acc + 1;
        q_data.push_back(int'(px_data));
        q_x.push_back(int'(px_x));
        q_y.push_back(int'(px_y));
        q_last.push_back(int'(px_last));
        q_cyc.push_back(cyc + 1);
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc + 1;
      end
      if (iss - acc > max_out) max_out = iss - acc;
      if (IRAM_web !== 1'b1) web_bad = web_bad + 1;
    end else begin
      iss = 0;
      acc = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag,
          {IRAM_ceb, IRAM_web, IRAM_A, px_valid, px_data, px_x, px_y, px_last, checksum, busy, done},
          {1'b0, 1'b1, 6'd0, 1'b0, 8'd0, 3'd0, 3'd0, 1'b0, 16'd0, 1'b0, 1'b0});
  endtask

  task automatic fill(input bit ff);
    for (int i = 0; i < 64; i++) mem[i] = ff ? 8'hFF : 8'(i);
  endtask

  // mode 0: ready high, 1: 10-cycle stall at beat 20, 2: toggling ready,
  // 3: extra starts at beat 30 and in FIN, 4: reset at beat 40
  task automatic run_frame(input int mode, input bit ff);
    int base, dbase, k, hold, nacc, budget, nb, derr, xyerr, lerr, expd;
    bit s30;
    base  = q_data.size();
    dbase = done_cnt;
    hold  = 0;
    s30   = 1'b0;
    px_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = cyc;
    check("busy_at_k1", busy, 1);
    check("ceb_at_k1", IRAM_ceb, 1);
    check("addr_at_k1", IRAM_A, 0);
    check("checksum_clr_at_k1", checksum, 0);
    budget = 0;
    while (done_cnt == dbase && budget < 400) begin
      nacc = q_data.size() - base;
      case (mode)
        1: begin
          if (nacc == 20 && hold < 10) begin
            check("stall_hold_beat20", {px_valid, px_data, px_x, px_y, px_last},
                  {1'b1, 8'd20, 3'd4, 3'd2, 1'b0});
            px_ready = 1'b0;
            hold++;
          end else begin
            px_ready = 1'b1;
          end
        end
        2: px_ready = ~px_ready;
        3: begin
          px_ready = 1'b1;
          start = 1'b0;
          if (nacc == 30 && !s30) begin
            start = 1'b1;
            s30 = 1'b1;
          end
          if (done === 1'b1) start = 1'b1;
        end
        4: begin
          if (nacc == 40) begin
            rst_n = 1'b0;
            #1;
            check_reset_vals("reset_midframe_outputs");
            repeat (3) @(posedge clk);
            #1;
            check_reset_vals("reset_held_outputs");
            rst_n = 1'b1;
            repeat (6) @(posedge clk);
            #1;
            check("no_done_after_reset", done_cnt - dbase, 0);
            check("idle_after_reset", {busy, px_valid, IRAM_ceb}, 3'b000);
            return;
          end
          px_ready = 1'b1;
        end
        default: px_ready = 1'b1;
      endcase
      @(posedge clk); #1;
      budget++;
    end
    start = 1'b0;
    px_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("done_exactly_once", done_cnt - dbase, 1);
    check("idle_after_done", {busy, px_valid}, 2'b00);
    nb = q_data.size() - base;
    check("beat_count", nb, 64);
    derr = 0; xyerr = 0; lerr = 0;
    for (int i = 0; i < nb && i < 64; i++) begin
      expd = ff ? 255 : i;
      if (q_data[base+i] != expd) derr++;
      if (q_x[base+i] != (i % 8) || q_y[base+i] != (i / 8)) xyerr++;
      if (q_last[base+i] != ((i == 63) ? 1 : 0)) lerr++;
    end
    check("data_order_errors", derr, 0);
    check("xy_errors", xyerr, 0);
    check("last_flag_errors", lerr, 0);
    check("checksum", checksum, ff ? 16'h3FC0 : 16'h07E0);
    if (mode == 0 && nb == 64) begin
      check("first_beat_cycle", q_cyc[base], k + 3);
      check("last_beat_cycle", q_cyc[base+63], k + 66);
      check("done_cycle", done_cyc, k + 67);
    end
    if (mode == 2 && nb == 64) begin
      check("done_after_last_accept", done_cyc > q_cyc[base+63], 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    px_ready = 1'b0;
    fill(1'b0);
    #3;
    check_reset_vals("reset_values");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    px_ready = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("idle_with_ready_high");

    run_frame(0, 1'b0);
    run_frame(1, 1'b0);
    run_frame(2, 1'b0);
    run_frame(3, 1'b0);
    fill(1'b1);
    run_frame(0, 1'b1);
    run_frame(0, 1'b1);
    fill(1'b0);
    run_frame(4, 1'b0);
    run_frame(0, 1'b0);

    check("max_reads_outstanding_le2", max_out <= 2, 1);
    check("never_wrote_iram", web_bad, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
